// File: rtl/dff_bank_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : dff_bank_arbiter
//  Purpose  : Round-robin arbiter and sequencer in front of one shared
//             WIDTH-bit D flip-flop register. One requester wins each
//             arbitration. Its data is loaded into the register and it
//             receives a one-cycle acknowledge. The register is then held
//             for HOLD_CYCLES cycles before the next arbitration opens.
//  Ports    : clk      - rising-edge clock
//             rst      - asynchronous active-high reset
//             req      - request vector, bit i = requester i
//             data     - write data, requester i drives [i*WIDTH +: WIDTH]
//             ack      - one-cycle write acknowledge (one-hot or zero)
//             grant_id - index of the most recent winner
//             q / nq   - register contents and its bitwise complement
//             busy     - high during the hold window
//  Revision : 1.0 - initial release
// ============================================================================
module dff_bank_arbiter #(
    parameter int N_REQ       = 4,
    parameter int WIDTH       = 8,
    parameter int HOLD_CYCLES = 2,
    localparam int ID_W       = $clog2(N_REQ)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*WIDTH-1:0] data,
    output logic [N_REQ-1:0]       ack,
    output logic [ID_W-1:0]        grant_id,
    output logic [WIDTH-1:0]       q,
    output logic [WIDTH-1:0]       nq,
    output logic                   busy
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    localparam logic [ID_W-1:0] c_last_id  = ID_W'(N_REQ - 1);
    localparam logic [ID_W:0]   c_n_req    = (ID_W + 1)'(N_REQ);
    localparam logic [7:0]      c_hold_ld  = 8'(HOLD_CYCLES - 1);

    state_t            r_state;
    logic [WIDTH-1:0]  r_q;
    logic [N_REQ-1:0]  r_ack;
    logic [ID_W-1:0]   r_grant_id;
    logic              r_busy;
    logic [ID_W-1:0]   r_ptr;
    logic [7:0]        r_cnt;

    logic              w_found;
    logic [ID_W-1:0]   w_win;
    logic [ID_W:0]     w_sum;
    logic [ID_W-1:0]   w_idx;
    logic [ID_W-1:0]   w_ptr_next;
    logic [WIDTH-1:0]  w_wdata;
    logic [N_REQ-1:0]  w_onehot;

    // Rotating priority scan: offset k from the pointer, wrapped modulo
    // N_REQ. The one-bit-wider sum keeps the wrap correct when N_REQ is
    // not a power of two. The first set bit found is the winner.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_sum   = '0;
        w_idx   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            w_sum = {1'b0, r_ptr} + (ID_W + 1)'(k);
            if (w_sum >= c_n_req) begin
                w_sum = w_sum - c_n_req;
            end
            w_idx = w_sum[ID_W-1:0];
            if (!w_found && req[w_idx]) begin
                w_found = 1'b1;
                w_win   = w_idx;
            end
        end
    end

    assign w_ptr_next = (w_win == c_last_id) ? '0 : w_win + 1'b1;
    assign w_wdata    = data[int'(w_win)*WIDTH +: WIDTH];
    assign w_onehot   = N_REQ'(1) << w_win;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_q        <= '0;
            r_ack      <= '0;
            r_grant_id <= '0;
            r_busy     <= 1'b0;
            r_ptr      <= '0;
            r_cnt      <= '0;
        end else if (r_state == IDLE) begin
            if (w_found) begin
                r_q        <= w_wdata;
                r_ack      <= w_onehot;
                r_grant_id <= w_win;
                r_ptr      <= w_ptr_next;
                r_cnt      <= c_hold_ld;
                r_busy     <= 1'b1;
                r_state    <= HOLD;
            end
        end else begin
            // Hold window: requests are ignored, register is frozen.
            r_ack <= '0;
            if (r_cnt == 8'd0) begin
                r_busy  <= 1'b0;
                r_state <= IDLE;
            end else begin
                r_cnt <= r_cnt - 8'd1;
            end
        end
    end

    assign q        = r_q;
    assign nq       = ~r_q;
    assign ack      = r_ack;
    assign grant_id = r_grant_id;
    assign busy     = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_dff_bank_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dff_bank_arbiter
//  Purpose  : Directed self-checking bench for dff_bank_arbiter with
//             N_REQ=4, WIDTH=8, HOLD_CYCLES=2.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_dff_bank_arbiter;

    logic        clk;
    logic        rst;
    logic [3:0]  req;
    logic [31:0] data;
    logic [3:0]  ack;
    logic [1:0]  grant_id;
    logic [7:0]  q;
    logic [7:0]  nq;
    logic        busy;

    int n_cmp;
    int n_err;

    dff_bank_arbiter #(
        .N_REQ       (4),
        .WIDTH       (8),
        .HOLD_CYCLES (2)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .data     (data),
        .ack      (ack),
        .grant_id (grant_id),
        .q        (q),
        .nq       (nq),
        .busy     (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Short reset pulse placed away from any clock edge.
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst  = 1'b1;
        req  = 4'b0000;
        data = 32'h0;
        #2;
        n_cmp++; if (q !== 8'h00) begin n_err++; $display("FAIL reset_q: got %h expected %h", q, 8'h00); end
        n_cmp++; if (nq !== 8'hFF) begin n_err++; $display("FAIL reset_nq: got %h expected %h", nq, 8'hFF); end
        n_cmp++; if (ack !== 4'b0000) begin n_err++; $display("FAIL reset_ack: got %b expected %b", ack, 4'b0000); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b expected %b", busy, 1'b0); end
        n_cmp++; if (grant_id !== 2'd0) begin n_err++; $display("FAIL reset_gid: got %0d expected %0d", grant_id, 0); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_single();
        data = {8'h44, 8'hA5, 8'h22, 8'h11};
        req  = 4'b0100;
        tick();
        n_cmp++; if (q !== 8'hA5) begin n_err++; $display("FAIL single_q: got %h expected %h", q, 8'hA5); end
        n_cmp++; if (nq !== 8'h5A) begin n_err++; $display("FAIL single_nq: got %h expected %h", nq, 8'h5A); end
        n_cmp++; if (ack !== 4'b0100) begin n_err++; $display("FAIL single_ack: got %b expected %b", ack, 4'b0100); end
        n_cmp++; if (grant_id !== 2'd2) begin n_err++; $display("FAIL single_gid: got %0d expected %0d", grant_id, 2); end
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL single_busy0: got %b expected %b", busy, 1'b1); end
        req = 4'b0000;
        tick();
        n_cmp++; if (ack !== 4'b0000) begin n_err++; $display("FAIL single_ack_width: got %b expected %b", ack, 4'b0000); end
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL single_busy1: got %b expected %b", busy, 1'b1); end
        n_cmp++; if (q !== 8'hA5) begin n_err++; $display("FAIL single_hold_q: got %h expected %h", q, 8'hA5); end
        tick();
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL single_busy2: got %b expected %b", busy, 1'b0); end
        n_cmp++; if (grant_id !== 2'd2) begin n_err++; $display("FAIL single_gid_keep: got %0d expected %0d", grant_id, 2); end
    endtask

    task automatic test_contention();
        logic [7:0] exp_q;
        logic [3:0] exp_ack;
        logic [1:0] exp_gid;
        do_reset();
        data = {8'h44, 8'h33, 8'h22, 8'h11};
        req  = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            exp_gid = 2'(i % 4);
            exp_q   = 8'(8'h11 * ((i % 4) + 1));
            exp_ack = 4'b0001 << exp_gid;
            tick();
            n_cmp++; if (q !== exp_q) begin n_err++; $display("FAIL cont_q[%0d]: got %h expected %h", i, q, exp_q); end
            n_cmp++; if (ack !== exp_ack) begin n_err++; $display("FAIL cont_ack[%0d]: got %b expected %b", i, ack, exp_ack); end
            n_cmp++; if (grant_id !== exp_gid) begin n_err++; $display("FAIL cont_gid[%0d]: got %0d expected %0d", i, grant_id, exp_gid); end
            tick();
            n_cmp++; if (ack !== 4'b0000) begin n_err++; $display("FAIL cont_ack_off[%0d]: got %b expected %b", i, ack, 4'b0000); end
            tick();
            n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL cont_idle[%0d]: got %b expected %b", i, busy, 1'b0); end
        end
        req = 4'b0000;
    endtask

    task automatic test_req_during_hold();
        do_reset();
        data = {8'hD3, 8'hC2, 8'hB1, 8'hA0};
        req  = 4'b0010;
        tick();
        n_cmp++; if (ack !== 4'b0010) begin n_err++; $display("FAIL hold_ack1: got %b expected %b", ack, 4'b0010); end
        req = 4'b1000;
        tick();
        n_cmp++; if (ack !== 4'b0000) begin n_err++; $display("FAIL hold_noack_a: got %b expected %b", ack, 4'b0000); end
        n_cmp++; if (q !== 8'hB1) begin n_err++; $display("FAIL hold_q: got %h expected %h", q, 8'hB1); end
        tick();
        n_cmp++; if (ack !== 4'b0000) begin n_err++; $display("FAIL hold_noack_b: got %b expected %b", ack, 4'b0000); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL hold_idle: got %b expected %b", busy, 1'b0); end
        tick();
        n_cmp++; if (ack !== 4'b1000) begin n_err++; $display("FAIL hold_ack3: got %b expected %b", ack, 4'b1000); end
        n_cmp++; if (q !== 8'hD3) begin n_err++; $display("FAIL hold_q3: got %h expected %h", q, 8'hD3); end
        req = 4'b0000;
        tick();
        tick();
    endtask

    // Continues from the grant to requester 3, so the pointer is at 0.
    task automatic test_wrap();
        req = 4'b1001;
        tick();
        n_cmp++; if (grant_id !== 2'd0) begin n_err++; $display("FAIL wrap_gid0: got %0d expected %0d", grant_id, 0); end
        n_cmp++; if (q !== 8'hA0) begin n_err++; $display("FAIL wrap_q0: got %h expected %h", q, 8'hA0); end
        req = 4'b1000;
        tick();
        tick();
        tick();
        n_cmp++; if (grant_id !== 2'd3) begin n_err++; $display("FAIL wrap_gid3: got %0d expected %0d", grant_id, 3); end
        n_cmp++; if (ack !== 4'b1000) begin n_err++; $display("FAIL wrap_ack3: got %b expected %b", ack, 4'b1000); end
        req = 4'b0000;
        tick();
        tick();
    endtask

    task automatic test_reset_mid_hold();
        do_reset();
        data = {8'h78, 8'h56, 8'h34, 8'h12};
        req  = 4'b0001;
        tick();
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL rmh_busy_pre: got %b expected %b", busy, 1'b1); end
        req = 4'b0000;
        #2;
        rst = 1'b1;
        #1;
        n_cmp++; if (q !== 8'h00) begin n_err++; $display("FAIL rmh_q: got %h expected %h", q, 8'h00); end
        n_cmp++; if (nq !== 8'hFF) begin n_err++; $display("FAIL rmh_nq: got %h expected %h", nq, 8'hFF); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rmh_busy: got %b expected %b", busy, 1'b0); end
        n_cmp++; if (ack !== 4'b0000) begin n_err++; $display("FAIL rmh_ack: got %b expected %b", ack, 4'b0000); end
        rst = 1'b0;
        tick();
        n_cmp++; if (ack !== 4'b0000) begin n_err++; $display("FAIL rmh_no_late_ack: got %b expected %b", ack, 4'b0000); end
        req = 4'b0011;
        tick();
        n_cmp++; if (grant_id !== 2'd0) begin n_err++; $display("FAIL rmh_gid: got %0d expected %0d", grant_id, 0); end
        n_cmp++; if (ack !== 4'b0001) begin n_err++; $display("FAIL rmh_ack0: got %b expected %b", ack, 4'b0001); end
        n_cmp++; if (q !== 8'h12) begin n_err++; $display("FAIL rmh_q0: got %h expected %h", q, 8'h12); end
        req = 4'b0000;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_single();
        test_contention();
        test_req_during_hold();
        test_wrap();
        test_reset_mid_hold();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dff_bank_arbiter.md
Name: dff_bank_arbiter

Overview:
- Round-robin arbiter and sequencer for a shared WIDTH-bit D flip-flop register. Up to N_REQ requesters compete to load it.
- One winner per arbitration is written into the register and acknowledged. The register is then held stable for HOLD_CYCLES cycles so downstream logic can sample it, after which the next arbitration opens.
- Outputs mirror the D_FF convention: true output q and complement nq.

Parameters:
- N_REQ, 4, number of requesters (2..16).
- WIDTH, 8, register width in bits.
- HOLD_CYCLES, 2, cycles the register is held after a write before re-arbitration (1..255).
- ID_W, $clog2(N_REQ), width of grant_id (derived, not overridden).

Ports:
- clk  input  1  system clock, rising-edge active.
- rst  input  1  asynchronous reset, active-high.
- req  input  N_REQ  request vector; bit i = requester i wants a write.
- data  input  N_REQ*WIDTH  write data; requester i drives bits [i*WIDTH +: WIDTH].
- ack  output  N_REQ  one-cycle write acknowledge, one-hot or zero.
- grant_id  output  ID_W  index of the most recent winner.
- q  output  WIDTH  shared register contents.
- nq  output  WIDTH  bitwise complement of q, always.
- busy  output  1  high while the register is in the hold window.

Behaviour:
- Interface: one clock, clk. Reset rst is asynchronous and active-high.
- Reset (async, effective immediately, independent of clk):
  - state=IDLE, q=0, nq=all ones, ack=0, grant_id=0, busy=0.
  - Round-robin pointer ptr=0, giving requester 0 top priority.
  - Hold counter=0.
- States: IDLE, HOLD. busy = (state==HOLD), registered.
- IDLE, req==0: no change.
- IDLE, req!=0:
  - Winner w = first set bit of req scanning ptr, ptr+1, ... N_REQ-1, 0, ... ptr-1 (mod N_REQ).
  - At the next rising edge: q<=data[w]; ack<=one-hot(w); grant_id<=w; ptr<=(w+1) mod N_REQ; counter<=HOLD_CYCLES-1; state<=HOLD.
  - Latency from sampled req to q/ack update is 1 edge.
- HOLD:
  - ack<=0 at the first edge in HOLD, so ack is exactly one cycle wide.
  - req is ignored and q is held.
  - counter decrements each edge. At the edge where counter==0, state<=IDLE.
  - busy is therefore high for exactly HOLD_CYCLES cycles, starting with the ack cycle.
- Throughput: one write per HOLD_CYCLES+1 cycles under continuous requests.
- Handshake:
  - A requester holds req and data stable until it sees its ack.
  - It deasserts req in the cycle after ack. A req still high when the arbiter returns to IDLE is treated as a new request.
  - req withdrawn before being granted has no effect and leaves no stored state.
- Pointer wrap: after a grant to N_REQ-1, ptr=0.
- Simultaneous requests: only the winner is acked. Losers stay pending, and the rotated ptr guarantees each is served within N_REQ arbitrations.
- Reset during HOLD: immediately forces all reset values, clearing q. The pending write sequence is abandoned and no ack follows.
- nq is combinationally ~q; it never diverges from q, including during reset.
- grant_id retains the last winner through HOLD and IDLE until the next grant.

Test Plan:
- Reset: rst=1 mid-simulation -> q=0x00, nq=0xFF, ack=0, busy=0, grant_id=0, without waiting for a clk edge.
- Single write (HOLD_CYCLES=2): req=4'b0100, data[2]=0xA5 in IDLE -> next edge q=0xA5, nq=0x5A, ack=4'b0100 for 1 cycle, grant_id=2, busy high 2 cycles, then IDLE.
- Full contention: req=4'b1111 held, data=0x11/0x22/0x33/0x44 -> grants in order 0,1,2,3,0. q sequence 0x11,0x22,0x33,0x44,0x11, one new value every 3 cycles.
- Request during HOLD: requester 1 granted, requester 3 raises req during busy -> no ack[3] until the first IDLE cycle; ack[3] on the following edge.
- Wrap: after a grant to 3 (ptr=0), req=4'b1001 -> grant 0, then 3 on the next arbitration.
- Reset mid-HOLD: rst pulsed between edges while busy=1 -> q=0, busy=0, ptr=0. Next req=4'b0011 grants requester 0.
